// File: rtl/AESDefinitions.sv
// Shared AES round-sequencer definitions: round count,
// 128-bit state type and sequencer FSM encoding.
package AESDefinitions;

    localparam int NUM_ROUNDS = 10;

    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } seq_state_t;

endpackage

// File: rtl/round_sequencer.sv
// Iterates one 128-bit block through NUM_ROUNDS+1 passes of an
// external combinational round datapath, with valid/ready on both sides.
module round_sequencer #(
    parameter int NUM_ROUNDS = AESDefinitions::NUM_ROUNDS,
    parameter int RW         = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          inValid,
    output logic          inReady,
    input  logic [127:0]  inData,
    output logic [RW-1:0] roundNum,
    output logic [127:0]  roundIn,
    input  logic [127:0]  roundOut,
    output logic          finalRound,
    output logic          outValid,
    input  logic          outReady,
    output logic [127:0]  outData,
    output logic          busy
);
    import AESDefinitions::*;

    localparam logic [RW-1:0] LAST = RW'(NUM_ROUNDS);

    seq_state_t      state, state_n;
    logic [RW-1:0]   round_n;
    state_t          state_reg, state_reg_n;
    state_t          out_n;
    logic            valid_n;
    logic            ready_c;

    always_comb begin
        state_n     = state;
        round_n     = roundNum;
        state_reg_n = state_reg;
        out_n       = outData;
        valid_n     = outValid;
        ready_c     = 1'b0;
        unique case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (inValid) begin
                    state_reg_n = inData;
                    round_n     = '0;
                    state_n     = ROUND;
                end
            end
            ROUND: begin
                state_reg_n = roundOut;
                if (roundNum == LAST) begin
                    out_n   = roundOut;
                    valid_n = 1'b1;
                    round_n = '0;
                    state_n = DONE;
                end else begin
                    round_n = roundNum + 1'b1;
                end
            end
            DONE: begin
                ready_c = outReady;
                if (outReady) begin
                    valid_n = 1'b0;
                    // Drain and refill on the same edge: no bubble
                    if (inValid) begin
                        state_reg_n = inData;
                        round_n     = '0;
                        state_n     = ROUND;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            roundNum  <= '0;
            state_reg <= '0;
            outData   <= '0;
            outValid  <= 1'b0;
        end else begin
            state     <= state_n;
            roundNum  <= round_n;
            state_reg <= state_reg_n;
            outData   <= out_n;
            outValid  <= valid_n;
        end
    end

    // Reset is synchronous, so mask the handshake while it is held
    assign inReady    = reset && ready_c;
    assign roundIn    = state_reg;
    assign busy       = (state == ROUND);
    assign finalRound = (state == ROUND) && (roundNum == LAST);

endmodule

// File: tb/tb_round_sequencer.sv
// Scoreboarded random/directed bench for round_sequencer with an
// increment-by-one stub round datapath.
module tb_round_sequencer;

    localparam int NR  = 10;
    localparam int RW  = 4;
    localparam int LAT = NR + 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          inValid;
    logic          inReady;
    logic [127:0]  inData;
    logic [RW-1:0] roundNum;
    logic [127:0]  roundIn;
    logic [127:0]  roundOut;
    logic          finalRound;
    logic          outValid;
    logic          outReady;
    logic [127:0]  outData;
    logic          busy;

    int total = 0;
    int bad   = 0;

    logic [127:0] exp_q[$];
    int           acc_q[$];
    int           cyc       = 0;
    int           fr_cnt    = 0;
    int           busy_cnt  = 0;
    bit           stalled   = 0;
    bit           prev_vld  = 0;
    bit           overlap   = 0;
    logic [127:0] held      = '0;

    round_sequencer #(.NUM_ROUNDS(NR), .RW(RW)) dut (
        .clock      (clock),
        .reset      (reset),
        .inValid    (inValid),
        .inReady    (inReady),
        .inData     (inData),
        .roundNum   (roundNum),
        .roundIn    (roundIn),
        .roundOut   (roundOut),
        .finalRound (finalRound),
        .outValid   (outValid),
        .outReady   (outReady),
        .outData    (outData),
        .busy       (busy)
    );

    assign roundOut = roundIn + 128'd1;

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor/scoreboard: samples on the falling edge, between updates
    always @(negedge clock) begin
        cyc++;
        if (!reset) begin
            exp_q.delete();
            acc_q.delete();
            fr_cnt   = 0;
            busy_cnt = 0;
            stalled  = 0;
            prev_vld = 0;
        end else begin
            if (finalRound) begin
                fr_cnt++;
                chk("final_idx", 128'(roundNum), 128'(NR));
            end
            if (busy) busy_cnt++;
            if (outValid && !prev_vld) begin
                if (acc_q.size() == 0) begin
                    chk("spurious_out", 128'(outValid), 128'd0);
                end else begin
                    chk("latency", 128'(cyc - acc_q.pop_front()), 128'(LAT));
                end
                chk("final_cnt", 128'(fr_cnt), 128'd1);
                chk("busy_cnt", 128'(busy_cnt), 128'(LAT));
                fr_cnt   = 0;
                busy_cnt = 0;
            end
            if (stalled) begin
                chk("hold_valid", 128'(outValid), 128'd1);
                chk("hold_data", outData, held);
            end
            if (outValid) chk("done_ready", 128'(inReady), 128'(outReady));
            if (outValid && outReady) begin
                if (exp_q.size() == 0) chk("unexpected_data", outData, 128'hx);
                else chk("out_data", outData, exp_q.pop_front());
                if (inValid && inReady) overlap = 1;
            end
            if (inValid && inReady) begin
                exp_q.push_back(inData + 128'(LAT));
                acc_q.push_back(cyc + 1);
            end
            stalled  = outValid && !outReady;
            held     = outData;
            prev_vld = outValid;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [127:0] d);
        int n;
        n = 0;
        inValid = 1'b1;
        inData  = d;
        @(negedge clock);
        while (!inReady && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) chk("send_timeout", 128'(n), 128'd0);
        step();
        inValid = 1'b0;
    endtask

    task automatic wait_out_hs();
        int n;
        n = 0;
        @(negedge clock);
        while (!(outValid && outReady) && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) chk("out_timeout", 128'(n), 128'd0);
        step();
    endtask

    initial begin
        int n;
        reset    = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        outReady = 1'b0;
        step();
        step();
        reset = 1'b1;
        @(negedge clock);
        chk("rst_valid", 128'(outValid), 128'd0);
        chk("rst_ready", 128'(inReady), 128'd1);
        chk("rst_round", 128'(roundNum), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        step();

        // Single block, downstream always ready
        outReady = 1'b1;
        send(128'd0);
        wait_out_hs();
        @(negedge clock);
        chk("idle_after", 128'(inReady), 128'd1);
        chk("idle_valid", 128'(outValid), 128'd0);
        step();

        // Downstream stall: result must hold, input ignored
        outReady = 1'b0;
        send(128'd0);
        n = 0;
        @(negedge clock);
        while (!outValid && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("stall_seen", 128'(outValid), 128'd1);
        step();
        for (int i = 0; i < 5; i++) begin
            inValid = 1'b1;
            inData  = 128'(55 + i);
            @(negedge clock);
            chk("stall_ready", 128'(inReady), 128'd0);
            chk("stall_data", outData, 128'd11);
            step();
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        wait_out_hs();
        @(negedge clock);
        chk("stall_idle", 128'(inReady), 128'd1);
        step();

        // Back-to-back with simultaneous output and input handshake
        overlap  = 0;
        inValid  = 1'b1;
        inData   = 128'd100;
        @(negedge clock);
        while (!inReady) @(negedge clock);
        step();
        inData = 128'd200;
        n = 0;
        @(negedge clock);
        while (!inReady && n < 50) begin
            @(negedge clock);
            n++;
        end
        step();
        inValid = 1'b0;
        chk("b2b_overlap", 128'(overlap), 128'd1);
        wait_out_hs();

        // Reset in the middle of a block aborts it
        send(128'd3);
        n = 0;
        @(negedge clock);
        while (roundNum != 5 && n < 50) begin
            @(negedge clock);
            n++;
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        @(negedge clock);
        chk("abort_valid", 128'(outValid), 128'd0);
        chk("abort_ready", 128'(inReady), 128'd1);
        chk("abort_round", 128'(roundNum), 128'd0);
        step();
        send(128'd7);
        wait_out_hs();

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            inValid  = ($urandom_range(1, 0) == 1);
            inData   = {$urandom(), $urandom(), $urandom(), $urandom()};
            outReady = ($urandom_range(9, 0) < 7);
            reset    = ($urandom_range(149, 0) != 0);
            step();
        end
        reset    = 1'b1;
        inValid  = 1'b0;
        outReady = 1'b1;
        for (int i = 0; i < 40; i++) step();
        chk("drain_empty", 128'(exp_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/round_sequencer.md
ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 Parameter: NUM_ROUNDS, default `NUM_ROUNDS from AESDefinitions (10), number of cipher rounds after the initial round.
REQ-002 Parameter: RW, default 4, width of the round index.
REQ-003 clock  in  1  single clock; all state updates on posedge clock.
REQ-004 reset  in  1  synchronous, active-low; asserted when 0, sampled only on posedge clock.
REQ-005 inValid  in  1  upstream block available.
REQ-006 inReady  out  1  sequencer accepts a block this cycle.
REQ-007 inData  in  128  input block; captured when inValid && inReady.
REQ-008 roundNum  out  RW  current round index, driven to key schedule and round datapath.
REQ-009 roundIn  out  128  current state register, driven to the combinational round datapath.
REQ-010 roundOut  in  128  datapath result for (roundIn, roundNum).
REQ-011 finalRound  out  1  high while roundNum == NUM_ROUNDS (datapath omits MixColumns).
REQ-012 outValid  out  1  result held in outData.
REQ-013 outReady  in  1  downstream accepts result.
REQ-014 outData  out  128  result register; stable while outValid && !outReady.
REQ-015 busy  out  1  high in ROUND state.

Function
REQ-016 The FSM SHALL have states IDLE, ROUND, DONE.
REQ-017 IDLE: inReady=1; on inValid, stateReg<=inData, roundNum<=0, go ROUND.
REQ-018 ROUND: each cycle stateReg<=roundOut and roundNum<=roundNum+1, until roundNum==NUM_ROUNDS.
REQ-019 ROUND with roundNum==NUM_ROUNDS: outData<=roundOut, outValid<=1, roundNum<=0, go DONE.
REQ-020 Latency: accept edge at cycle 0 -> outValid high after edge NUM_ROUNDS+1 (11 for NUM_ROUNDS=10); exactly NUM_ROUNDS+1 ROUND cycles.
REQ-021 DONE: outValid=1, outData held; inReady = outReady.
REQ-022 DONE, outReady=1, inValid=0: outValid<=0, go IDLE.
REQ-023 DONE, outReady=1, inValid=1 (simultaneous): output handshake and input capture complete same edge, go ROUND, roundNum<=0; no bubble.
REQ-024 DONE, outReady=0: no state change; inValid ignored, inReady=0.
REQ-025 inValid in ROUND SHALL be ignored (inReady=0); no input is lost because no handshake occurs.
REQ-026 roundIn SHALL equal stateReg combinationally; finalRound and busy are decoded from registered state only.
REQ-027 roundNum SHALL never exceed NUM_ROUNDS; increment is RW-bit, no wrap reachable.
REQ-028 outReady asserted outside DONE SHALL have no effect.

Reset
REQ-029 reset=0 at a clock edge SHALL force: state IDLE, roundNum 0, stateReg 0, outData 0, outValid 0.
REQ-030 Reset mid-ROUND or in DONE SHALL abort the block without output; first accept possible on the first edge after reset=1.
REQ-031 During reset inReady SHALL read 0; busy 0; finalRound 0.

Structure
REQ-032 AESDefinitions SHALL hold NUM_ROUNDS, the 128-bit state typedef, and the sequencer state enum.
REQ-033 No sub-module; round index counter and FSM reside in round_sequencer.

Verification (bench stub datapath: roundOut = roundIn + 1)
REQ-034 reset=0 for 2 cycles then 1 -> outValid=0, inReady=1, roundNum=0.
REQ-035 inData=0, inValid one cycle, outReady=1 -> outValid high exactly 11 cycles after accept, outData=11, then IDLE.
REQ-036 outReady=0 for 5 cycles after result -> outData=11 stable, inReady=0, inValid ignored; outReady=1 -> IDLE.
REQ-037 Back-to-back: inValid held high, inData=100 then 200, outReady=1 -> outputs 111 and 211, second accept on the cycle of first output handshake.
REQ-038 reset=0 at roundNum=5 -> next cycle IDLE, no outValid; new block inData=7 yields 18.
REQ-039 finalRound high exactly one cycle per block, coincident with roundNum=10.
